// File: rtl/pipeline_ctrl.sv
// Hazard / stall / flush sequencer for the 5-stage core.
// Resolves memory waits, branch flushes and load-use bubbles, and keeps saturating perf counters.
module pipeline_ctrl #(
  parameter int FLUSH_EXTRA = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [4:0]       rd_ex,
  input  logic             load_ex,
  input  logic             branch_taken_ex,
  input  logic             mem_access,
  input  logic             mem_ack,
  input  logic             perf_clr,
  output logic             hazard,
  output logic             stall_mem,
  output logic             flush,
  output logic             pc_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] hazard_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int FW = (FLUSH_EXTRA > 1) ? $clog2(FLUSH_EXTRA + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [FW-1:0]   left_q, left_d;
  logic            stall_c, flush_c, hz_c, to_c, accept_c, load_use;
  logic [CNT_W-1:0] stall_q, haz_q, flush_q;

  assign load_use = load_ex && (rd_ex != 5'd0) &&
                    ((rs1_used && (rs1_id == rd_ex)) || (rs2_used && (rs2_id == rd_ex)));

  always_comb begin
    state_d  = RUN;
    timer_d  = '0;
    left_d   = '0;
    stall_c  = 1'b0;
    flush_c  = 1'b0;
    hz_c     = 1'b0;
    to_c     = 1'b0;
    accept_c = 1'b0;
    if (state_q == MEM_WAIT) begin
      stall_c = !mem_ack && (timer_q != TMAX);
      to_c    = !mem_ack && (timer_q == TMAX);
    end else begin
      stall_c = mem_access && !mem_ack;
    end
    // Stall wins; a frozen EX re-presents its branch once memory releases.
    if (stall_c) begin
      state_d = MEM_WAIT;
      timer_d = (state_q == MEM_WAIT) ? timer_q + TW'(1) : TW'(1);
    end else if (branch_taken_ex) begin
      flush_c  = 1'b1;
      accept_c = 1'b1;
      if (FLUSH_EXTRA > 0) begin
        state_d = FLUSH;
        left_d  = FW'(FLUSH_EXTRA);
      end
    end else if (state_q == FLUSH) begin
      flush_c = 1'b1;
      if (left_q > FW'(1)) begin
        state_d = FLUSH;
        left_d  = left_q - FW'(1);
      end
    end
    hz_c = load_use && !stall_c && !flush_c;
    if (rst) begin
      stall_c  = 1'b0;
      flush_c  = 1'b0;
      hz_c     = 1'b0;
      to_c     = 1'b0;
      accept_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      timer_q <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      left_q  <= left_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      stall_q <= '0;
      haz_q   <= '0;
      flush_q <= '0;
    end else begin
      if (stall_c  && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (hz_c     && (haz_q   != '1)) haz_q   <= haz_q   + CNT_W'(1);
      if (accept_c && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hazard       = hz_c;
  assign stall_mem    = stall_c;
  assign flush        = flush_c;
  assign pc_hold      = hz_c || stall_c;
  assign mem_timeout  = to_c;
  // Counters read as zero for the whole reset cycle, not just after the edge.
  assign stall_cycles = rst ? '0 : stall_q;
  assign hazard_count = rst ? '0 : haz_q;
  assign flush_count  = rst ? '0 : flush_q;
endmodule
